// File: rtl/md_pkg.sv
// ============================================================================
// Module   : md_pkg
// Purpose  : Shared op encodings, latencies and FSM states for the mult/div unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package md_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [3:0] MULT_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES  = 4'd10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    function automatic logic is_arith(input logic [2:0] op);
        return op <= OP_DIVU;
    endfunction

    function automatic logic [3:0] op_cycles(input logic [2:0] op);
        return (op == OP_MULT || op == OP_MULTU) ? MULT_CYCLES : DIV_CYCLES;
    endfunction

endpackage

`default_nettype wire

// File: rtl/md_calc.sv
// ============================================================================
// Module   : md_calc
// Purpose  : Combinational 64-bit product / quotient-remainder of latched operands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_calc
    import md_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_result,
    output logic        o_write_en
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_div_b;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic        w_signed_div;
    logic        w_neg_q;
    logic        w_neg_r;

    always_comb begin
        // Low 64 bits of the product of sign-extended operands is the signed product
        w_prod_s     = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
        w_prod_u     = {32'd0, i_a} * {32'd0, i_b};

        // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000, rem 0
        w_signed_div = (i_op == OP_DIV);
        w_abs_a      = (w_signed_div && i_a[31]) ? (~i_a + 32'd1) : i_a;
        w_abs_b      = (w_signed_div && i_b[31]) ? (~i_b + 32'd1) : i_b;
        w_div_b      = (i_b == 32'd0) ? 32'd1 : w_abs_b;
        w_quot       = w_abs_a / w_div_b;
        w_rem        = w_abs_a % w_div_b;
        w_neg_q      = w_signed_div && (i_a[31] ^ i_b[31]);
        w_neg_r      = w_signed_div && i_a[31];

        o_result     = 64'd0;
        o_write_en   = 1'b0;
        case (i_op)
            OP_MULT: begin
                o_result   = w_prod_s;
                o_write_en = 1'b1;
            end
            OP_MULTU: begin
                o_result   = w_prod_u;
                o_write_en = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                o_result   = {(w_neg_r ? (~w_rem + 32'd1) : w_rem),
                              (w_neg_q ? (~w_quot + 32'd1) : w_quot)};
                o_write_en = (i_b != 32'd0);
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/md_ctrl.sv
// ============================================================================
// Module   : md_ctrl
// Purpose  : Multi-cycle mult/div controller with HI/LO registers and stall.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_ctrl
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        wr,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        d_md_use,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_t   r_state;
    logic [3:0]  r_cnt;
    logic [2:0]  r_op;
    logic [31:0] r_opa;
    logic [31:0] r_opb;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic [63:0] w_result;
    logic        w_write_en;

    md_calc u_calc (
        .i_op       (r_op),
        .i_a        (r_opa),
        .i_b        (r_opb),
        .o_result   (w_result),
        .o_write_en (w_write_en)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_op    <= 3'd0;
            r_opa   <= 32'd0;
            r_opb   <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A raised start blocks the move-to write even if its op is not arithmetic
                    if (start) begin
                        if (is_arith(op)) begin
                            r_op    <= op;
                            r_opa   <= opa;
                            r_opb   <= opb;
                            r_cnt   <= op_cycles(op);
                            r_state <= ST_BUSY;
                            r_busy  <= 1'b1;
                        end
                    end else if (wr) begin
                        if (op == OP_MTHI) begin
                            r_hi <= opa;
                        end else if (op == OP_MTLO) begin
                            r_lo <= opa;
                        end
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        if (w_write_en) begin
                            r_hi <= w_result[63:32];
                            r_lo <= w_result[31:0];
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign stall_md = d_md_use & (start | r_busy);

endmodule

`default_nettype wire

// File: tb/tb_md_ctrl.sv
// ============================================================================
// Module   : tb_md_ctrl
// Purpose  : Scoreboard testbench for md_ctrl with a reference arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        wr = 1'b0;
    logic [31:0] opa = 32'd0;
    logic [31:0] opb = 32'd0;
    logic        d_md_use = 1'b0;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        logic [31:0] new_hi;
        logic [31:0] new_lo;
        int          cycles;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] ref_hi = 32'd0;
    logic [31:0] ref_lo = 32'd0;

    md_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .wr       (wr),
        .opa      (opa),
        .opb      (opb),
        .d_md_use (d_md_use),
        .busy     (busy),
        .stall_md (stall_md),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain 64-bit integer arithmetic on the architectural operands
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] h,
                                          input logic [31:0] l);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            3'd0: return sa * sb;
            3'd1: return ua * ub;
            3'd2: begin
                if (b == 32'd0) return {h, l};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 32'd0) return {h, l};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            default: return {h, l};
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Launch an arithmetic op and follow its busy/stall timeline; results are scored by the monitor
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic use_d, input logic with_wr, input logic disturb);
        exp_t e;
        int   n;
        n = (o < 3'd2) ? 5 : 10;
        e.old_hi = ref_hi;
        e.old_lo = ref_lo;
        {e.new_hi, e.new_lo} = model(o, a, b, ref_hi, ref_lo);
        e.cycles = n;
        exp_q.push_back(e);
        ref_hi = e.new_hi;
        ref_lo = e.new_lo;
        @(posedge clk); #1;
        start = 1'b1; op = o; opa = a; opb = b; d_md_use = use_d; wr = with_wr;
        @(negedge clk);
        chk("stall_start", {31'd0, stall_md}, {31'd0, use_d});
        @(posedge clk); #1;
        start = 1'b0; wr = 1'b0; opa = $urandom; opb = $urandom;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("busy_run", {31'd0, busy}, 32'd1);
            chk("stall_busy", {31'd0, stall_md}, {31'd0, use_d});
            if (disturb) begin
                if (i == 1) begin
                    start = 1'b1; op = 3'd3; opa = 32'd50; opb = 32'd3;
                end else if (i == 2) begin
                    start = 1'b0; wr = 1'b1; op = 3'd4; opa = 32'hDEAD_BEEF;
                end else if (i == 3) begin
                    wr = 1'b0;
                end
            end
        end
        @(negedge clk);
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk("stall_done", {31'd0, stall_md}, 32'd0);
        d_md_use = 1'b0;
    endtask

    task automatic mtx(input logic [2:0] o, input logic [31:0] v);
        @(posedge clk); #1;
        wr = 1'b1; op = o; opa = v;
        if (o == 3'd4) ref_hi = v;
        if (o == 3'd5) ref_lo = v;
        @(posedge clk); #1;
        wr = 1'b0;
        @(negedge clk);
        chk("mt_busy", {31'd0, busy}, 32'd0);
        chk("mt_hi", hi, ref_hi);
        chk("mt_lo", lo, ref_lo);
    endtask

    task automatic noop(input logic [2:0] o);
        @(posedge clk); #1;
        start = 1'b1; wr = 1'b1; op = o; opa = $urandom;
        @(posedge clk); #1;
        start = 1'b0; wr = 1'b0;
        @(negedge clk);
        chk("noop_busy", {31'd0, busy}, 32'd0);
        chk("noop_hi", hi, ref_hi);
        chk("noop_lo", lo, ref_lo);
    endtask

    // Monitor: HI/LO must hold during busy; each busy fall (not caused by reset) retires one entry
    initial begin : monitor
        exp_t e;
        int   run;
        logic prev_busy;
        logic prev_reset;
        run = 0;
        prev_busy = 1'b0;
        prev_reset = 1'b1;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                run++;
                if (exp_q.size() > 0) begin
                    chk("hold_hi", hi, exp_q[0].old_hi);
                    chk("hold_lo", lo, exp_q[0].old_lo);
                end
            end else begin
                if (prev_busy && !prev_reset) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL done_unexpected: busy fell with no pending op at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result_hi", hi, e.new_hi);
                        chk("result_lo", lo, e.new_lo);
                        chk("busy_len", run, e.cycles);
                    end
                end
                run = 0;
            end
            prev_busy = busy;
            prev_reset = reset;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [2:0] o;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        d_md_use = 1'b1;
        @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, stall_md}, 32'd0);
        d_md_use = 1'b0;

        issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, 1'b0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        issue(3'd3, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
        chk("divu_hi", hi, 32'd2);
        chk("divu_lo", lo, 32'd14);

        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 1'b0);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        chk("div_lo", lo, 32'hFFFF_FFFD);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        chk("ovf_hi", hi, 32'd0);
        chk("ovf_lo", lo, 32'h8000_0000);

        mtx(3'd4, 32'h11);
        mtx(3'd5, 32'h22);
        issue(3'd2, 32'h1234_5678, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("dz_hi", hi, 32'h11);
        chk("dz_lo", lo, 32'h22);
        issue(3'd3, 32'hCAFE_0000, 32'd0, 1'b0, 1'b0, 1'b0);

        issue(3'd1, 32'd7, 32'd9, 1'b1, 1'b0, 1'b1);
        chk("ignore_hi", hi, 32'd0);
        chk("ignore_lo", lo, 32'd63);

        // Reset during the third busy cycle of a divide
        issue_abort: begin
            exp_t e;
            @(posedge clk); #1;
            start = 1'b1; op = 3'd2; opa = 32'd1000; opb = 32'd7;
            e.old_hi = ref_hi; e.old_lo = ref_lo;
            e.new_hi = ref_hi; e.new_lo = ref_lo; e.cycles = 10;
            exp_q.push_back(e);
            @(posedge clk); #1;
            start = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            reset = 1'b1; start = 1'b1; wr = 1'b1; op = 3'd5; opa = 32'h77;
            exp_q.delete();
            ref_hi = 32'd0;
            ref_lo = 32'd0;
            @(posedge clk); #1;
            reset = 1'b0; start = 1'b0; wr = 1'b0;
            @(negedge clk);
            chk("abort_busy", {31'd0, busy}, 32'd0);
            chk("abort_hi", hi, 32'd0);
            chk("abort_lo", lo, 32'd0);
        end
        mtx(3'd5, 32'h5);
        chk("mtlo_after_rst", lo, 32'd5);

        noop(3'd6);
        noop(3'd7);

        for (int k = 0; k < 40; k++) begin
            o = 3'($urandom_range(0, 7));
            if (o <= 3'd3) begin
                issue(o, pick(), pick(), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end else if (o <= 3'd5) begin
                mtx(o, $urandom);
            end else begin
                noop(o);
            end
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
